ram_access_ctrl: RTL

- Single-clock controller that shares the 8x64 byte-enabled, column-read RAM between one write requester and one read requester.
- Arbitrates round-robin between the two, sequences the RAM strobes (rnw, wa/ra, active-low be, din_valid), and captures the registered column read data.
- Sits directly in front of the RAM; the RAM's clk and pci_clk are both tied to this block's clk.

---
 rtl/ram_ctrl_pkg.sv | 32 +++
 rtl/rr_arb2.sv | 46 ++++
 rtl/ram_access_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// ============================================================================
// ram_ctrl_pkg
// Shared types and RAM-fixed widths for the RAM access controller.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package ram_ctrl_pkg;

    // Widths fixed by the 8x64 byte-enabled RAM
    localparam int ADDR_W = 3;
    localparam int DATA_W = 64;
    localparam int BE_W   = DATA_W / 8;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR     = 2'd1,
        RD     = 2'd2,
        RD_CAP = 2'd3
    } state_e;

    // Arbiter grant encoding
    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_e;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2
// Two-requester round-robin arbiter. req[0] is the writer, req[1] the reader.
// The last-grant register starts at GNT_RD so the writer wins first contention.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rr_arb2
    import ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output grant_e     grant_o,
    output logic       valid_o
);

    grant_e last_q;

    // Grant the sole requester, or the one not served last on contention
    always_comb begin
        valid_o = |req_i;
        grant_o = GNT_WR;
        case (req_i)
            2'b01:   grant_o = GNT_WR;
            2'b10:   grant_o = GNT_RD;
            2'b11:   grant_o = (last_q == GNT_RD) ? GNT_WR : GNT_RD;
            default: grant_o = GNT_WR;
        endcase
    end

    // Remember who was served whenever a grant is actually taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= GNT_RD;
        end else if (advance_i && valid_o) begin
            last_q <= grant_o;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_access_ctrl.sv
// ============================================================================
// ram_access_ctrl
// Shares the 8x64 column-read RAM between one writer and one reader:
// round-robin arbitration, RAM strobe sequencing, read-data capture and
// saturating completion counters. Every output is registered.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count,
    output logic              ram_rnw,
    output logic [ADDR_W-1:0] ram_wa,
    output logic [ADDR_W-1:0] ram_ra,
    output logic [BE_W-1:0]   ram_be,
    output logic [DATA_W-1:0] ram_di,
    output logic              ram_din_valid,
    input  logic [DATA_W-1:0] ram_do
);

    state_e              state_q;
    logic                wr_ack_q, rd_ack_q, rd_valid_q, busy_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [CNT_W-1:0]    wr_count_q, wr_count_d;
    logic [CNT_W-1:0]    rd_count_q, rd_count_d;
    logic                ram_rnw_q, ram_din_valid_q;
    logic [ADDR_W-1:0]   ram_wa_q, ram_ra_q;
    logic [BE_W-1:0]     ram_be_q;
    logic [DATA_W-1:0]   ram_di_q;

    grant_e              w_grant;
    logic                w_grant_valid;
    logic                w_advance;

    assign w_advance = (state_q == IDLE);

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     ({rd_req, wr_req}),
        .advance_i (w_advance),
        .grant_o   (w_grant),
        .valid_o   (w_grant_valid)
    );

    // Saturating increments: counters stick at all-ones
    always_comb begin
        wr_count_d = (wr_count_q == {CNT_W{1'b1}}) ? wr_count_q : wr_count_q + 1'b1;
        rd_count_d = (rd_count_q == {CNT_W{1'b1}}) ? rd_count_q : rd_count_q + 1'b1;
    end

    // Sequencer: captures the granted request and drives the RAM strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            ram_rnw_q       <= 1'b1;
            ram_din_valid_q <= 1'b0;
            ram_be_q        <= {BE_W{1'b1}};
            ram_wa_q        <= '0;
            ram_ra_q        <= '0;
            ram_di_q        <= '0;
            wr_ack_q        <= 1'b0;
            rd_ack_q        <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_data_q       <= '0;
            busy_q          <= 1'b0;
            wr_count_q      <= '0;
            rd_count_q      <= '0;
        end else begin
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_grant_valid) begin
                        busy_q <= 1'b1;
                        if (w_grant == GNT_WR) begin
                            state_q         <= WR;
                            ram_wa_q        <= wr_addr;
                            ram_be_q        <= ~wr_be;
                            ram_di_q        <= wr_data;
                            ram_din_valid_q <= 1'b1;
                            wr_ack_q        <= 1'b1;
                        end else begin
                            state_q   <= RD;
                            ram_rnw_q <= 1'b0;
                            ram_ra_q  <= rd_addr;
                            rd_ack_q  <= 1'b1;
                        end
                    end
                end
                WR: begin
                    // The RAM write lands on this edge; fall back to idle drive
                    state_q         <= IDLE;
                    ram_din_valid_q <= 1'b0;
                    ram_be_q        <= {BE_W{1'b1}};
                    busy_q          <= 1'b0;
                    wr_count_q      <= wr_count_d;
                end
                RD: begin
                    // The RAM loads the column on this edge; rnw high holds it
                    state_q   <= RD_CAP;
                    ram_rnw_q <= 1'b1;
                end
                RD_CAP: begin
                    state_q    <= IDLE;
                    rd_data_q  <= ram_do;
                    rd_valid_q <= 1'b1;
                    busy_q     <= 1'b0;
                    rd_count_q <= rd_count_d;
                end
                default: begin
                    state_q         <= IDLE;
                    ram_rnw_q       <= 1'b1;
                    ram_din_valid_q <= 1'b0;
                    ram_be_q        <= {BE_W{1'b1}};
                    busy_q          <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ack        = wr_ack_q;
    assign rd_ack        = rd_ack_q;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign busy          = busy_q;
    assign wr_count      = wr_count_q;
    assign rd_count      = rd_count_q;
    assign ram_rnw       = ram_rnw_q;
    assign ram_wa        = ram_wa_q;
    assign ram_ra        = ram_ra_q;
    assign ram_be        = ram_be_q;
    assign ram_di        = ram_di_q;
    assign ram_din_valid = ram_din_valid_q;

endmodule

`default_nettype wire
